scan_mux_n: RTL
===============

# scan_mux_n

Parametrised N-to-1 registered multiplexer for W-bit channels, with a valid/ready output handshake and two selection modes: fixed select and round-robin auto-scan over a channel mask. It is the sequential successor to the team's fixed 32:1 single-bit combinational mux tree. It sits between a bank of parallel data sources and a single downstream consumer that is allowed to stall.

## Interface

Parameters:
- N, default 32: channel count; power of two, at least 2.
- W, default 8: data width per channel.
- SW, default $clog2(N): select and channel-index width; derived, not overridden.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: sampling enable.
- mode, input, 1: 0 = fixed select, 1 = auto-scan.
- sel, input, SW: channel index used in fixed mode.
- ch_mask, input, N: scan-eligible channels (bit i = channel i); ignored in fixed mode.
- din, input, N*W: channel i occupies din[i*W +: W].
- out_data, output, W: registered sample.
- out_ch, output, SW: index of the channel that out_data came from.
- out_valid, output, 1: out_data/out_ch hold a sample not yet accepted.
- out_ready, input, 1: consumer accepts the sample when out_valid && out_ready.

## Operation

- Define advance = !out_valid || out_ready. The output register may load only when advance = 1; otherwise all outputs and ptr hold (stall).
- Internal state ptr (SW bits) is the last channel sampled in scan mode.
- Candidate selection when advance = 1:
  - en = 0: out_valid <= 0. out_data, out_ch and ptr hold.
  - en = 1, mode = 0: load out_data <= din[sel], out_ch <= sel, out_valid <= 1. ptr is unchanged.
  - en = 1, mode = 1, ch_mask != 0: the chosen channel c is the first set mask bit searching ptr+1, ptr+2, … modulo N, wrapping N-1 -> 0. The search includes ptr itself as the last candidate. Load out_data <= din[c], out_ch <= c, out_valid <= 1, ptr <= c.
  - en = 1, mode = 1, ch_mask == 0: out_valid <= 0. ptr, out_data and out_ch hold.
- Mode changes take effect at the next advance. Scan resumes from the held ptr; fixed-mode samples never move ptr.
- The mask, sel and din values used are those present in the advancing cycle. Changes during a stall have no effect until the stall releases.
- Arithmetic: ptr+k is computed mod N, which is natural SW-bit wrap because N is a power of two.
- Reset (asynchronous assert, any time, including during a stall): out_valid = 0, out_data = 0, out_ch = 0, ptr = N-1. The first scan therefore starts at channel 0. Reset release is synchronous to clk by the integrating design.

## Timing

- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- Throughput: one sample per cycle while out_ready = 1 continuously.
- Handshake: while out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid are stable. out_valid never drops without an accept, except on reset.
- Simultaneous accept and load in the same cycle is the normal back-to-back case; there is no bubble.
- In scan mode with a single mask bit set, the same channel repeats every cycle.
- The round-robin search is combinational from ptr and ch_mask. The critical path is the N-wide rotate-priority search plus the N:1 data mux, both contained in one stage.

## Test plan

1. **Reset.** Assert rst_n = 0 mid-stream with out_valid = 1 and out_ready = 0.
   - Outputs go to 0 immediately, without waiting for clk.
   - After release with mode = 1, ch_mask = all ones and en = 1, out_ch sequence is 0, 1, 2, ….
2. **Fixed mode.** N = 32, W = 8, din[i] = i+0x40, out_ready = 1; sel steps 0, 31, 5.
   - out_data = 0x40, 0x5F, 0x45 one cycle after each sel.
   - out_ch matches sel.
3. **Scan wrap.** ch_mask = 0x8000_0003, out_ready = 1.
   - out_ch = 0, 1, 31, 0, 1, 31, … with no idle cycles.
4. **Backpressure.** Scan mode with out_ready held 0 for 5 cycles after the first valid, and din changed during the stall.
   - out_ch and out_data are frozen, and ptr does not advance.
   - After out_ready = 1, the next channel follows the frozen one.
5. **Empty mask and en low.**
   - With ch_mask = 0, or with en = 0, out_valid goes 0 after the pending sample is accepted.
   - On restoring ch_mask = 0x10, out_ch = 4 on the next cycle.
6. **Mode switch.** Scan to out_ch = 7, switch to fixed sel = 20 for 3 samples, then return to scan with all ones.
   - out_ch = 20, 20, 20, then 8.

Source files
------------

// File: rtl/scan_mux_n.sv
// scan_mux_n: N-to-1 registered multiplexer for W-bit channels.
// It has a valid/ready output handshake and two selection modes: fixed select,
// and round-robin auto-scan over a channel mask.
// The round-robin pointer remembers the last channel sampled in scan mode, so
// a scan always resumes after the channel it visited last.
module scan_mux_n #(
  parameter  int N  = 32,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    ch_mask,
  input  logic [N*W-1:0]  din,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q,   out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,      ptr_d;

  logic [W-1:0]  ch_data [N];
  logic          advance;
  logic          found;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = din[i*W +: W];
  end

  assign advance = !out_valid_q || out_ready;

  // Rotate-priority search: first set mask bit from ptr+1 upward, ptr itself last.
  // The offset k=N truncates to 0, which is ptr itself.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ptr_q + SW'(k);
      if (!found && ch_mask[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state for the output register and the scan pointer; all hold while stalled.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (advance) begin
      if (!en) begin
        out_valid_d = 1'b0;
      end else if (!mode) begin
        out_data_d  = ch_data[sel];
        out_ch_d    = sel;
        out_valid_d = 1'b1;
      end else if (found) begin
        out_data_d  = ch_data[pick];
        out_ch_d    = pick;
        out_valid_d = 1'b1;
        ptr_d       = pick;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers.
  // ptr resets to N-1 so that the first scan after reset lands on channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
